// File: rtl/scan_display_pkg.sv
// rtl/scan_display_pkg.sv - shared types, segment codes and polarity helpers for scan_display_ctrl
//
// Purpose : FSM state type, the hex-to-7-segment code table (active-high,
//           seg[0]=a .. seg[6]=g) and helpers that apply output polarity.
// Ports   : none (package)
package scan_display_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // All segments inactive for the given polarity.
    function automatic logic [6:0] SEG_OFF(input logic active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    // Map an active-high segment pattern onto the pin polarity.
    function automatic logic [6:0] SEG_ON(input logic [6:0] code, input logic active_low);
        return active_low ? ~code : code;
    endfunction

endpackage

// File: rtl/scan_display_ctrl_hex_seg7_decode.sv
// rtl/scan_display_ctrl_hex_seg7_decode.sv - combinational hex nibble to active-high 7-segment decoder
//
// Purpose : full 0-F decode to active-high segments.
// Ports   : nibble (in, 4)  hex value
//           seg    (out, 7) active-high segments, seg[0]=a .. seg[6]=g
module hex_seg7_decode
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_CODE[nibble];

endmodule

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - multiplexed 7-segment display scanner with dead time and frame-synchronous update
//
// Purpose : scans N_DIGITS digits; each slot is BLANK_CYCLES of all-off dead
//           time followed by DIG_CYCLES of one digit driven. New data is loaded
//           into a pending register and only moved to the display register at
//           the end of a full frame, so a frame never shows mixed data.
// Ports   : clk        (in)             rising-edge clock
//           rst        (in)             asynchronous active-high reset
//           data_in    (in, 4*N_DIGITS) hex nibble per digit, digit 0 = [3:0]
//           dp_in      (in, N_DIGITS)   decimal point request per digit
//           load       (in)             one-cycle capture strobe
//           dig_en     (out, N_DIGITS)  digit enables (polarity per ACTIVE_LOW)
//           seg        (out, 7)         segments a..g (polarity per ACTIVE_LOW)
//           dp         (out)            decimal point (polarity per ACTIVE_LOW)
//           frame_done (out)            one-cycle pulse on the last cycle of a frame
// Config  : define SCAN_DISPLAY_LZB_EN to enable leading-zero blanking.
module scan_display_ctrl
    import scan_display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIG_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     dig_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int MAXC = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(N_DIGITS);

    localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]       DIG_LAST   = CW'(DIG_CYCLES - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic                AL         = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] DIG_OFF    = {N_DIGITS{AL}};
    localparam logic [N_DIGITS-1:0] DIG_ONE    = {{(N_DIGITS-1){1'b0}}, 1'b1};

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    frame_end;
    logic                    frame_done_n;

    logic [4*N_DIGITS-1:0]   disp_data, pend_data;
    logic [N_DIGITS-1:0]     disp_dp, pend_dp;
    logic                    pend_flag;

    logic [6:0]              dec_seg;
    logic [6:0]              seg_act;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        idx_n     = idx;
        frame_end = 1'b0;
        if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_n = ST_DRIVE;
                cnt_n   = '0;
            end
        end else begin
            if (cnt == DIG_LAST) begin
                state_n   = ST_BLANK;
                cnt_n     = '0;
                idx_n     = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                frame_end = (idx == IDX_LAST);
            end
        end
    end

    // Outputs are registered from the next-state values so the pins line up
    // with the cycle the FSM is actually in, without adding a cycle of lag.
    assign frame_done_n = (state_n == ST_DRIVE) && (cnt_n == DIG_LAST) && (idx_n == IDX_LAST);

    // ---------------- pending / display registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            // A load on the frame_end cycle keeps the flag set and is shown
            // one frame later; the older pending value moves to the display.
            pend_flag <= load | (pend_flag & ~frame_end);
            if (frame_end && pend_flag) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
            end
        end
    end

    // disp_data only changes on the edge into BLANK, so reading it here with
    // the next index is safe for every DRIVE cycle.
    hex_seg7_decode u_dec (
        .nibble (disp_data[{idx_n, 2'b00} +: 4]),
        .seg    (dec_seg)
    );

`ifdef SCAN_DISPLAY_LZB_EN
    logic lz_blank;

    // Blank a digit above 0 when it and every higher nibble are zero.
    always_comb begin
        lz_blank = (idx_n != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((i >= int'(idx_n)) && (disp_data[4*i +: 4] != 4'h0))
                lz_blank = 1'b0;
        end
    end

    assign seg_act = lz_blank ? 7'h00 : dec_seg;
`else
    assign seg_act = dec_seg;
`endif

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en     <= DIG_OFF;
            seg        <= SEG_OFF(AL);
            dp         <= AL;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_done_n;
            if (state_n == ST_DRIVE) begin
                dig_en <= (DIG_ONE << idx_n) ^ DIG_OFF;
                seg    <= SEG_ON(seg_act, AL);
                dp     <= disp_dp[idx_n] ^ AL;
            end else begin
                dig_en <= DIG_OFF;
                seg    <= SEG_OFF(AL);
                dp     <= AL;
            end
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - scoreboard bench for scan_display_ctrl (4 digits, 4 drive, 2 blank, active-low)
module tb_scan_display_ctrl;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    scan_display_ctrl #(
        .N_DIGITS     (4),
        .DIG_CYCLES   (4),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .dig_en     (dig_en),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int k);
        logic [3:0] nib;
        nib = d[4*k +: 4];
`ifdef SCAN_DISPLAY_LZB_EN
        if (k > 0 && (d >> (4*k)) == 16'h0)
            return 7'h7F;
`endif
        return ~SEG_TBL[nib];
    endfunction

    // Expected {dig_en, seg, dp} at the start of each of the next cnt slots.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [3:0] den;
            den    = 4'hF;
            den[k] = 1'b0;
            exp_q.push_back({den, exp_seg(d, k), ~dpv[k]});
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done)
            check("fd_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; load is seen by exactly one rising edge.
    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
        load    = 1'b1;
        data_in = d;
        dp_in   = dpv;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Monitor: slot contents, slot/blank lengths, frame period.
    initial begin
        logic [3:0]  prev_den;
        int          drv_len;
        int          blk_len;
        int          fd_gap;
        bit          fd_seen;
        logic [11:0] e;
        prev_den = 4'hF;
        drv_len  = 0;
        blk_len  = 1;
        fd_gap   = 0;
        fd_seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_den = 4'hF;
                drv_len  = 0;
                // The reset-state cycle in which rst releases is the first blank cycle.
                blk_len  = 1;
                fd_seen  = 1'b0;
            end else begin
                if (dig_en != 4'hF) begin
                    if (prev_den == 4'hF) begin
                        check("blank_len", blk_len, 2);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("slot", {dig_en, seg, dp}, e);
                        end
                        drv_len = 0;
                    end
                    drv_len++;
                end else begin
                    if (prev_den != 4'hF) begin
                        check("slot_len", drv_len, 4);
                        blk_len = 0;
                    end
                    blk_len++;
                    check("blank_out", {seg, dp}, 8'hFF);
                end
                if (frame_done) begin
                    check("fd_digit", dig_en, 4'b0111);
                    if (fd_seen)
                        check("fd_period", fd_gap, 24);
                    fd_seen = 1'b1;
                    fd_gap  = 0;
                end
                fd_gap++;
                prev_den = dig_en;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dig_en", dig_en, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fd", frame_done, 1'b0);

        // Frame 1 shows reset data; load lands for frame 2.
        push_frame(16'h0000, 4'b0000, 4);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        do_load(16'h12AF, 4'b0100);
        wait_fd();
        push_frame(16'h12AF, 4'b0100, 4);

        // Two loads within frame 3: frame 3 unchanged, last one wins in frame 4.
        wait_fd();
        push_frame(16'h12AF, 4'b0100, 4);
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (6) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        wait_fd();
        push_frame(16'h2222, 4'b0000, 4);

        // Load in the frame_done cycle: frame 5 unchanged, frame 6 shows it.
        wait_fd();
        push_frame(16'h2222, 4'b0000, 4);
        do_load(16'h3C5E, 4'b1001);
        wait_fd();
        push_frame(16'h3C5E, 4'b1001, 4);

        // Reset during digit 2 with a pending load.
        wait_fd();
        push_frame(16'h3C5E, 4'b1001, 3);
        repeat (2) @(negedge clk);
        do_load(16'h9999, 4'b1111);
        n = 0;
        while (dig_en !== 4'b1011 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_dig2", dig_en, 4'b1011);
        #2 rst = 1'b1;
        #1;
        check("async_dig_en", dig_en, 4'hF);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dp, 1'b1);
        push_frame(16'h0000, 4'b0000, 4);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        wait_fd();
        push_frame(16'h0000, 4'b0000, 4);

        // Leading-zero patterns.
        wait_fd();
        push_frame(16'h0000, 4'b0000, 4);
        repeat (3) @(negedge clk);
        do_load(16'h0050, 4'b0000);
        wait_fd();
        push_frame(16'h0050, 4'b0000, 4);
        repeat (3) @(negedge clk);
        do_load(16'h0000, 4'b0000);
        wait_fd();
        push_frame(16'h0000, 4'b0000, 4);
        wait_fd();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
